// File: rtl/pre_map_pkg.sv
// Shared constants and the operand class encoding for the sin/cos pre-mapping front end.
package pre_map_pkg;

  localparam int EXP_WIDTH  = 8;
  localparam int FRAC_WIDTH = 32;
  localparam int EXP_BIAS   = 127;

  // NaN and Inf both report the largest unbiased exponent; the fraction
  // constants give the top bits of the fraction, left-aligned at FRAC_WIDTH-1.
  localparam int         EXP_SPECIAL  = 127;
  localparam logic       FRAC_INF_TOP = 1'b1;
  localparam logic [1:0] FRAC_NAN_TOP = 2'b11;

  localparam logic [7:0] FP32_EXP_ZERO = 8'h00;
  localparam logic [7:0] FP32_EXP_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fp_class_e;

endpackage

// File: rtl/fp32_classify.sv
// Combinational binary32 decode: sign, unbiased exponent, left-aligned fraction and class.
module fp32_classify #(
  parameter int EXP_WIDTH  = pre_map_pkg::EXP_WIDTH,
  parameter int FRAC_WIDTH = pre_map_pkg::FRAC_WIDTH
) (
  input  logic [31:0]           i_data,
  output logic                  o_sign,
  output logic [EXP_WIDTH-1:0]  o_exp,
  output logic [FRAC_WIDTH-1:0] o_frac,
  output pre_map_pkg::fp_class_e o_cls
);
  import pre_map_pkg::*;

  logic [7:0]        w_bexp;
  logic [22:0]       w_man;
  logic signed [8:0] w_exp_unb;

  assign w_bexp    = i_data[30:23];
  assign w_man     = i_data[22:0];
  assign w_exp_unb = $signed({1'b0, w_bexp}) - $signed(9'(EXP_BIAS));

  always_comb begin
    o_sign = i_data[31];
    o_exp  = EXP_WIDTH'(w_exp_unb);
    o_frac = FRAC_WIDTH'({1'b1, w_man}) << (FRAC_WIDTH - 24);
    o_cls  = CLS_NORMAL;
    // Subnormals are flushed to zero together with true zeros.
    if (w_bexp == FP32_EXP_ZERO) begin
      o_exp  = '0;
      o_frac = '0;
      o_cls  = CLS_ZERO;
    end else if (w_bexp == FP32_EXP_MAX) begin
      o_exp = EXP_WIDTH'(EXP_SPECIAL);
      if (w_man == '0) begin
        o_frac = FRAC_WIDTH'(FRAC_INF_TOP) << (FRAC_WIDTH - 1);
        o_cls  = CLS_INF;
      end else begin
        o_frac = FRAC_WIDTH'(FRAC_NAN_TOP) << (FRAC_WIDTH - 2);
        o_sign = 1'b0;
        o_cls  = CLS_NAN;
      end
    end
  end

endmodule

// File: rtl/pre_map_unpack.sv
// Two-stage elastic pipeline: decode into S1, then register the bundle in S2 for dist_compress.
module pre_map_unpack #(
  parameter int EXP_WIDTH  = pre_map_pkg::EXP_WIDTH,
  parameter int FRAC_WIDTH = pre_map_pkg::FRAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_data,
  input  logic                  i_sincos,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sign_a,
  output logic [EXP_WIDTH-1:0]  o_exp_a,
  output logic [FRAC_WIDTH-1:0] o_frac_a,
  output logic                  o_sincos,
  output logic                  o_nan_flag,
  output logic                  o_inf_flag,
  output logic                  o_zero_flag
);
  import pre_map_pkg::*;

  // Handshake: a beat moves on a rising edge where valid and ready are both
  // high; a stage loads when it is empty or its contents are leaving.
  logic                  w_s2_en;
  logic                  w_s1_en;
  logic                  w_sign;
  logic [EXP_WIDTH-1:0]  w_exp;
  logic [FRAC_WIDTH-1:0] w_frac;
  fp_class_e             w_cls;

  logic                  r_s1_valid;
  logic                  r_s1_sign;
  logic [EXP_WIDTH-1:0]  r_s1_exp;
  logic [FRAC_WIDTH-1:0] r_s1_frac;
  logic                  r_s1_sincos;
  fp_class_e             r_s1_cls;

  logic                  r_s2_valid;
  logic                  r_s2_sign;
  logic [EXP_WIDTH-1:0]  r_s2_exp;
  logic [FRAC_WIDTH-1:0] r_s2_frac;
  logic                  r_s2_sincos;
  fp_class_e             r_s2_cls;

  fp32_classify #(
    .EXP_WIDTH  (EXP_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_classify (
    .i_data (i_data),
    .o_sign (w_sign),
    .o_exp  (w_exp),
    .o_frac (w_frac),
    .o_cls  (w_cls)
  );

  assign w_s2_en = ~r_s2_valid | i_ready;
  assign w_s1_en = ~r_s1_valid | w_s2_en;
  assign o_ready = w_s1_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= '0;
      r_s1_frac   <= '0;
      r_s1_sincos <= 1'b0;
      r_s1_cls    <= CLS_NORMAL;
    end else if (w_s1_en) begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_sign   <= w_sign;
        r_s1_exp    <= w_exp;
        r_s1_frac   <= w_frac;
        r_s1_sincos <= i_sincos;
        r_s1_cls    <= w_cls;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_exp    <= '0;
      r_s2_frac   <= '0;
      r_s2_sincos <= 1'b0;
      r_s2_cls    <= CLS_NORMAL;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sign   <= r_s1_sign;
        r_s2_exp    <= r_s1_exp;
        r_s2_frac   <= r_s1_frac;
        r_s2_sincos <= r_s1_sincos;
        r_s2_cls    <= r_s1_cls;
      end
    end
  end

  assign o_valid     = r_s2_valid;
  assign o_sign_a    = r_s2_sign;
  assign o_exp_a     = r_s2_exp;
  assign o_frac_a    = r_s2_frac;
  assign o_sincos    = r_s2_sincos;
  assign o_nan_flag  = (r_s2_cls == CLS_NAN);
  assign o_inf_flag  = (r_s2_cls == CLS_INF);
  assign o_zero_flag = (r_s2_cls == CLS_ZERO);

endmodule

// File: tb/tb_pre_map_unpack.sv
// Directed bench for pre_map_unpack: decode vectors, streaming, back-pressure and mid-flight reset.
module tb_pre_map_unpack;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        i_sincos;
  logic        o_valid;
  logic        i_ready;
  logic        o_sign_a;
  logic [7:0]  o_exp_a;
  logic [31:0] o_frac_a;
  logic        o_sincos;
  logic        o_nan_flag;
  logic        o_inf_flag;
  logic        o_zero_flag;

  int n_checks = 0;
  int n_errors = 0;

  // Expected bundle: {sign, exp, frac, sincos, nan, inf, zero}
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [31:0] frac;
    logic        sincos;
    logic        nan;
    logic        inf;
    logic        zero;
  } bundle_t;

  pre_map_unpack dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_sincos    (i_sincos),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sign_a    (o_sign_a),
    .o_exp_a     (o_exp_a),
    .o_frac_a    (o_frac_a),
    .o_sincos    (o_sincos),
    .o_nan_flag  (o_nan_flag),
    .o_inf_flag  (o_inf_flag),
    .o_zero_flag (o_zero_flag)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_bundle(input string tag, input bundle_t e);
    chk({tag, ".valid"},  32'(o_valid),     32'd1);
    chk({tag, ".sign"},   32'(o_sign_a),    32'(e.sign));
    chk({tag, ".exp"},    32'(o_exp_a),     32'(e.exp));
    chk({tag, ".frac"},   o_frac_a,         e.frac);
    chk({tag, ".sincos"}, 32'(o_sincos),    32'(e.sincos));
    chk({tag, ".nan"},    32'(o_nan_flag),  32'(e.nan));
    chk({tag, ".inf"},    32'(o_inf_flag),  32'(e.inf));
    chk({tag, ".zero"},   32'(o_zero_flag), 32'(e.zero));
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic sc);
    i_valid  = v;
    i_data   = d;
    i_sincos = sc;
  endtask

  logic [31:0] vec_in [8];
  logic        vec_sc [8];
  bundle_t     vec_ex [8];

  initial begin
    // reset state
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    i_ready = 1'b1;
    #1;
    chk("rst.o_valid", 32'(o_valid), 32'd0);
    chk("rst.o_ready", 32'(o_ready), 32'd1);
    tick();
    tick();
    chk("rst.o_frac", o_frac_a, 32'h0);
    chk("rst.o_exp", 32'(o_exp_a), 32'h0);
    chk("rst.flags", 32'({o_nan_flag, o_inf_flag, o_zero_flag}), 32'h0);
    rst_n = 1'b1;
    tick();

    // single operand: latency of exactly two edges
    drive(1'b1, 32'h3F800000, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("one.lat1_valid", 32'(o_valid), 32'd0);
    tick();
    chk_bundle("one", '{1'b0, 8'h00, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    chk("one.drained", 32'(o_valid), 32'd0);

    // back-to-back stream with i_ready held high
    vec_in[0] = 32'hC0500000; vec_sc[0] = 1'b0; vec_ex[0] = '{1'b1, 8'h01, 32'hD0000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vec_in[1] = 32'h00800000; vec_sc[1] = 1'b1; vec_ex[1] = '{1'b0, 8'h82, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vec_in[2] = 32'h7FC00000; vec_sc[2] = 1'b0; vec_ex[2] = '{1'b0, 8'h7F, 32'hC0000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vec_in[3] = 32'hFF800000; vec_sc[3] = 1'b1; vec_ex[3] = '{1'b1, 8'h7F, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vec_in[4] = 32'h00000001; vec_sc[4] = 1'b0; vec_ex[4] = '{1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vec_in[5] = 32'h80000000; vec_sc[5] = 1'b1; vec_ex[5] = '{1'b1, 8'h00, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vec_in[6] = 32'hFFC00001; vec_sc[6] = 1'b0; vec_ex[6] = '{1'b0, 8'h7F, 32'hC0000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vec_in[7] = 32'h7F7FFFFF; vec_sc[7] = 1'b1; vec_ex[7] = '{1'b0, 8'h7F, 32'hFFFFFF00, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(1'b1, vec_in[i], vec_sc[i]);
      else       drive(1'b0, 32'h0, 1'b0);
      chk($sformatf("str%0d.o_ready", i), 32'(o_ready), 32'd1);
      tick();
      if (i >= 1) chk_bundle($sformatf("str%0d", i - 1), vec_ex[i - 1]);
    end
    tick();
    chk("str.drained", 32'(o_valid), 32'd0);

    // back-pressure: four operands, i_ready low for three edges
    drive(1'b1, 32'h41200000, 1'b1);
    tick();
    drive(1'b1, 32'h3E800000, 1'b0);
    tick();
    i_ready = 1'b0;
    drive(1'b1, 32'hC2C80000, 1'b1);
    #1;
    chk("stl.o_ready_full", 32'(o_ready), 32'd0);
    chk_bundle("stl.a0", '{1'b0, 8'h03, 32'hA0000000, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("stl%0d.o_ready", k), 32'(o_ready), 32'd0);
      chk_bundle($sformatf("stl%0d.a_hold", k), '{1'b0, 8'h03, 32'hA0000000, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    i_ready = 1'b1;
    #1;
    chk("stl.o_ready_release", 32'(o_ready), 32'd1);
    tick();
    drive(1'b1, 32'h7F800000, 1'b0);
    chk_bundle("stl.b", '{1'b1 ^ 1'b1, 8'hFE, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0});
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk_bundle("stl.c", '{1'b1, 8'h06, 32'hC8000000, 1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    chk_bundle("stl.d", '{1'b0, 8'h7F, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0});
    tick();
    chk("stl.drained", 32'(o_valid), 32'd0);

    // reset with two operands in flight
    drive(1'b1, 32'h40490FDB, 1'b1);
    tick();
    drive(1'b1, 32'h3F800000, 1'b0);
    tick();
    chk("rfl.pre_valid", 32'(o_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rfl.o_valid_async", 32'(o_valid), 32'd0);
    chk("rfl.o_ready_in_rst", 32'(o_ready), 32'd1);
    drive(1'b1, 32'h3F800000, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rfl%0d.no_output", k), 32'(o_valid), 32'd0);
    end
    drive(1'b1, 32'hBF000000, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    chk("rfl.new_lat1", 32'(o_valid), 32'd0);
    tick();
    chk_bundle("rfl.new", '{1'b1, 8'hFF, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0});
    tick();
    chk("rfl.drained", 32'(o_valid), 32'd0);

    // report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
